// File: rtl/adder_pipelined_if.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pipelined_if
//  Purpose  : Operand/result handshake bundle for adder_pipelined.
//             The producer side (master) offers operands and takes results;
//             the adder (slave) accepts operands and presents results.
//  Revision : 1.0 - initial release
// ============================================================================
interface adder_pipelined_if #(
  parameter int WIDTH = 17
);
  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/adder_pipelined.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pipelined
//  Purpose  : Carry-segmented pipelined adder/subtractor with valid/ready
//             handshake. The WIDTH-bit carry chain is split into STAGES
//             segments of SW = ceil(WIDTH/STAGES) bits; each compute stage
//             resolves one segment and hands its carry to the next stage.
//             Stage 0 is the operand register, stage STAGES is the output
//             register. The whole pipe advances together (global stall).
//  Revision : 1.0 - initial release
// ============================================================================
module adder_pipelined #(
  parameter int WIDTH  = 17,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_pipelined_if.slave bus
);

  // Segment width: the widest carry chain any single stage has to resolve.
  localparam int SW = (WIDTH + STAGES - 1) / STAGES;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
    $error("adder_pipelined: WIDTH=%0d outside 1..256", WIDTH);
  end

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $error("adder_pipelined: STAGES=%0d outside 1..WIDTH", STAGES);
  end

  // Every segment must hold at least one bit; otherwise the last stage would
  // have nothing to add and the latency would no longer match STAGES.
  if (((WIDTH + SW - 1) / SW) != STAGES) begin : g_empty_segment
    $error("adder_pipelined: WIDTH=%0d STAGES=%0d leaves an empty segment",
           WIDTH, STAGES);
  end

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  // Index k of the pipe arrays is the register bank feeding compute stage k+1:
  // index 0 is the operand register, higher indices are the skew banks.
  logic             adv;                 // whole pipe moves this edge
  logic             valid_q  [STAGES];   // per-bank valid bits
  logic             out_valid_q;         // output-register valid bit

  logic [WIDTH-1:0] a_q      [STAGES];   // operand A (skewed; sign kept)
  logic [WIDTH-1:0] b_q      [STAGES];   // operand B, already inverted for sub
  logic             carry_q  [STAGES];   // carry into the next segment
  logic [WIDTH-1:0] acc_q    [STAGES];   // finished low segments (deskew)

  logic [WIDTH-1:0] acc_nx   [STAGES];   // bank k after its segment is added
  logic             carry_nx [STAGES];   // carry out of segment k

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [WIDTH-1:0] b_prep;              // b' = sub ? ~b : b
  logic             c_prep;              // c0 = sub ? ~cin : cin
  logic             ovf_nx;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  // The pipe only stops when a presented result is being refused; a bubble at
  // the output never blocks the input.
  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  // --------------------------------------------------------------------------
  // Operand preparation
  // --------------------------------------------------------------------------
  // Subtraction is a + ~b + ~cin, so a borrow-in becomes a missing +1 and the
  // final carry-out reads as "no borrow".
  assign b_prep = bus.sub ? ~bus.b   : bus.b;
  assign c_prep = bus.sub ? ~bus.cin : bus.cin;

  // --------------------------------------------------------------------------
  // Per-segment adders
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    localparam int LO    = k * SW;
    localparam int HI_EX = ((k + 1) * SW < WIDTH) ? (k + 1) * SW : WIDTH;
    localparam int SEGW  = HI_EX - LO;
    localparam int HI    = LO + SEGW - 1;
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SEGW{1'b1}}) << LO;

    logic [SEGW:0] seg;

    // One (SEGW+1)-bit add: segment of a, segment of b', carry from below.
    assign seg = {1'b0, a_q[k][HI:LO]}
               + {1'b0, b_q[k][HI:LO]}
               + {{SEGW{1'b0}}, carry_q[k]};

    // Merge this segment's sum into the partial result travelling with it.
    assign acc_nx[k]   = (acc_q[k] & ~MASK) | (WIDTH'(seg[SEGW-1:0]) << LO);
    assign carry_nx[k] = seg[SEGW];
  end

  // Signed overflow: operands of equal sign produced a sum of the other sign.
  assign ovf_nx = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
               && (acc_nx[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------
  // Datapath banks: no reset needed, they only move when the pipe advances.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_q[0]     <= bus.a;
      b_q[0]     <= b_prep;
      carry_q[0] <= c_prep;
      acc_q[0]   <= '0;
      for (int k = 1; k < STAGES; k++) begin
        a_q[k]     <= a_q[k-1];
        b_q[k]     <= b_q[k-1];
        carry_q[k] <= carry_nx[k-1];
        acc_q[k]   <= acc_nx[k-1];
      end
    end
  end

  // Valid bits and output register: cleared asynchronously, advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      valid_q[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      out_valid_q <= valid_q[STAGES-1];
      sum_q       <= acc_nx[STAGES-1];
      cout_q      <= carry_nx[STAGES-1];
      ovf_q       <= ovf_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_pipelined.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_adder_pipelined
//  Purpose  : Scoreboard bench for adder_pipelined. Instance 0 (17,2) gets
//             directed vectors, backpressure and mid-flight reset; every
//             instance then streams random vectors against an arithmetic
//             reference model with random out_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_pipelined;

  localparam int N = 7;

  function automatic int cfg_w(int i);
    case (i)
      0: return 17;  1: return 1;   2: return 8;  3: return 17;
      4: return 17;  5: return 64;  6: return 32;
      default: return 17;
    endcase
  endfunction

  function automatic int cfg_s(int i);
    case (i)
      0: return 2;  1: return 1;  2: return 1;  3: return 2;
      4: return 17; 5: return 4;  6: return 3;
      default: return 2;
    endcase
  endfunction

  typedef struct {
    logic [255:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_edge;
    int           acc_sc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  // Drive / observe arrays, one slot per DUT instance
  logic         rst_arr     [N];
  logic [255:0] d_a         [N];
  logic [255:0] d_b         [N];
  logic         d_sub       [N];
  logic         d_cin       [N];
  logic         d_in_valid  [N];
  logic         d_out_ready [N];
  logic         o_in_ready  [N];
  logic         o_out_valid [N];
  logic [255:0] o_sum       [N];
  logic         o_cout      [N];
  logic         o_ovf       [N];

  exp_t exp_q     [N][$];
  int   mode      [N];   // 0: always ready, 1: random ready, 2: refuse
  int   sc        [N];   // stall edges seen so far
  bit   presented [N];
  bit   go = 0;
  int   done_cnt = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input bit ok, input string name, input string got, input string want);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  // Reference: plain wide arithmetic on the mathematical values.
  // Returns {ovf, cout, sum[255:0]}.
  function automatic logic [257:0] model(input int w, input logic [255:0] a_in,
                                         input logic [255:0] b_in, input logic sub,
                                         input logic cin);
    logic [257:0] m, a, b, t, sa, sb, r, ext;
    logic cout, ovf;
    m = (258'(1) << w) - 258'(1);
    a = 258'(a_in) & m;
    b = 258'(b_in) & m;
    if (!sub) begin
      t    = a + b + 258'(cin);
      cout = t[w];
    end else begin
      t    = a - b - 258'(cin);
      cout = (a >= b + 258'(cin));
    end
    sa  = a[w-1] ? (a | ~m) : a;
    sb  = b[w-1] ? (b | ~m) : b;
    r   = sub ? (sa - sb - 258'(cin)) : (sa + sb + 258'(cin));
    ext = r[w-1] ? (r | ~m) : (r & m);
    ovf = (ext != r);
    t   = t & m;
    return {ovf, cout, t[255:0]};
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // DUT instances
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < N; g++) begin : g_cfg
    localparam int W = cfg_w(g);
    localparam int S = cfg_s(g);

    adder_pipelined_if #(.WIDTH(W)) bus ();

    assign bus.in_valid  = d_in_valid[g];
    assign bus.a         = d_a[g][W-1:0];
    assign bus.b         = d_b[g][W-1:0];
    assign bus.sub       = d_sub[g];
    assign bus.cin       = d_cin[g];
    assign bus.out_ready = d_out_ready[g];
    assign o_in_ready[g]  = bus.in_ready;
    assign o_out_valid[g] = bus.out_valid;
    assign o_sum[g]       = 256'(bus.sum);
    assign o_cout[g]      = bus.cout;
    assign o_ovf[g]       = bus.ovf;

    adder_pipelined #(.WIDTH(W), .STAGES(S)) dut (
      .clk   (clk),
      .rst_n (rst_arr[g]),
      .bus   (bus.slave)
    );

    // Monitor: compares whatever the DUT presents against the queue head
    initial begin
      forever begin
        @(negedge clk);
        mon_step(g, S);
      end
    end

    // Random phase stimulus
    initial begin
      wait (go);
      rand_stream(g, 1000);
      done_cnt++;
    end
  end

  task automatic mon_step(input int id, input int s);
    exp_t e;
    case (mode[id])
      0:       d_out_ready[id] = 1'b1;
      1:       d_out_ready[id] = ($urandom_range(0, 3) != 0);
      default: d_out_ready[id] = 1'b0;
    endcase
    #1;
    if (o_out_valid[id] !== 1'b1) return;
    if (exp_q[id].size() == 0) begin
      chk(1'b0, $sformatf("unexpected_output[%0d]", id),
          $sformatf("sum=%h", o_sum[id]), "no result pending");
      return;
    end
    e = exp_q[id][0];
    if (!presented[id]) begin
      presented[id] = 1'b1;
      chk(edge_no == e.acc_edge + s + (sc[id] - e.acc_sc),
          $sformatf("latency[%0d]", id),
          $sformatf("edge %0d", edge_no),
          $sformatf("edge %0d", e.acc_edge + s + (sc[id] - e.acc_sc)));
    end
    chk(o_sum[id] === e.sum, $sformatf("sum[%0d]", id),
        $sformatf("%h", o_sum[id]), $sformatf("%h", e.sum));
    chk(o_cout[id] === e.cout, $sformatf("cout[%0d]", id),
        $sformatf("%b", o_cout[id]), $sformatf("%b", e.cout));
    chk(o_ovf[id] === e.ovf, $sformatf("ovf[%0d]", id),
        $sformatf("%b", o_ovf[id]), $sformatf("%b", e.ovf));
    if (!d_out_ready[id]) begin
      chk(o_in_ready[id] === 1'b0, $sformatf("in_ready_stall[%0d]", id),
          $sformatf("%b", o_in_ready[id]), "0");
      sc[id]++;
    end else begin
      void'(exp_q[id].pop_front());
      presented[id] = 1'b0;
    end
  endtask

  // Offer one operand set and hold it until accepted; the expected result is
  // queued for the edge that takes it.
  task automatic send(input int id, input logic [255:0] a, input logic [255:0] b,
                      input logic sub, input logic cin, input logic [255:0] es,
                      input logic ec, input logic eo);
    exp_t e;
    int   tries;
    @(negedge clk);
    d_a[id] = a; d_b[id] = b; d_sub[id] = sub; d_cin[id] = cin;
    d_in_valid[id] = 1'b1;
    #1;
    tries = 0;
    while (o_in_ready[id] !== 1'b1 && tries < 200) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (o_in_ready[id] !== 1'b1) begin
      chk(1'b0, $sformatf("accept_timeout[%0d]", id), "in_ready=0", "in_ready=1");
      d_in_valid[id] = 1'b0;
      return;
    end
    e.sum = es; e.cout = ec; e.ovf = eo;
    e.acc_edge = edge_no + 1;
    e.acc_sc   = sc[id];
    exp_q[id].push_back(e);
  endtask

  task automatic send_rand(input int id);
    logic [255:0] a, b;
    logic sub, cin;
    logic [257:0] r;
    a = rnd256(); b = rnd256();
    sub = $urandom_range(0, 1); cin = $urandom_range(0, 1);
    r = model(cfg_w(id), a, b, sub, cin);
    send(id, a, b, sub, cin, r[255:0], r[256], r[257]);
  endtask

  task automatic idle(input int id);
    @(negedge clk);
    d_in_valid[id] = 1'b0;
  endtask

  task automatic rand_stream(input int id, input int n);
    mode[id] = 1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) idle(id);
      send_rand(id);
    end
    idle(id);
  endtask

  task automatic wait_drain(input int id);
    int t = 0;
    while (exp_q[id].size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk(exp_q[id].size() == 0, $sformatf("drain[%0d]", id),
        $sformatf("%0d pending", exp_q[id].size()), "0 pending");
  endtask

  // Watchdog
  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < N; i++) begin
      rst_arr[i] = 1'b0; d_a[i] = '0; d_b[i] = '0; d_sub[i] = 1'b0; d_cin[i] = 1'b0;
      d_in_valid[i] = 1'b0; d_out_ready[i] = 1'b1;
      mode[i] = 0; sc[i] = 0; presented[i] = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      chk(o_out_valid[i] === 1'b0, $sformatf("rst_out_valid[%0d]", i), $sformatf("%b", o_out_valid[i]), "0");
      chk(o_in_ready[i] === 1'b1, $sformatf("rst_in_ready[%0d]", i), $sformatf("%b", o_in_ready[i]), "1");
      chk(o_sum[i] === '0 && o_cout[i] === 1'b0 && o_ovf[i] === 1'b0,
          $sformatf("rst_data[%0d]", i),
          $sformatf("sum=%h cout=%b ovf=%b", o_sum[i], o_cout[i], o_ovf[i]), "all zero");
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) rst_arr[i] = 1'b1;

    // Directed vectors on the (17,2) instance
    send(0, 256'h1FFFF, 256'h00001, 1'b0, 1'b0, 256'h00000, 1'b1, 1'b0);
    send(0, 256'd5,     256'd7,     1'b1, 1'b0, 256'h1FFFE, 1'b0, 1'b0);
    send(0, 256'd7,     256'd5,     1'b1, 1'b1, 256'h00001, 1'b1, 1'b0);
    send(0, 256'h0FFFF, 256'h00001, 1'b0, 1'b0, 256'h10000, 1'b0, 1'b1);
    send(0, 256'h10000, 256'h00001, 1'b1, 1'b0, 256'h0FFFF, 1'b1, 1'b1);
    idle(0);
    wait_drain(0);

    // Backpressure: 8 back-to-back sets with a 3-cycle refusal mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(0);
      end
      begin
        repeat (3) @(posedge clk);
        mode[0] = 2;
        repeat (3) @(posedge clk);
        mode[0] = 0;
      end
    join
    idle(0);
    wait_drain(0);

    // Reset mid-operation with a result held at the output
    mode[0] = 2;
    send(0, 256'd100, 256'd23, 1'b0, 1'b0, 256'd123, 1'b0, 1'b0);
    send(0, 256'd9,   256'd4,  1'b1, 1'b0, 256'd5,   1'b1, 1'b0);
    idle(0);
    repeat (3) @(negedge clk);
    #2;
    chk(o_out_valid[0] === 1'b1, "held_before_reset", $sformatf("%b", o_out_valid[0]), "1");
    rst_arr[0] = 1'b0;
    #1;
    chk(o_out_valid[0] === 1'b0, "midrst_out_valid", $sformatf("%b", o_out_valid[0]), "0");
    chk(o_in_ready[0] === 1'b1, "midrst_in_ready", $sformatf("%b", o_in_ready[0]), "1");
    chk(o_sum[0] === '0 && o_cout[0] === 1'b0 && o_ovf[0] === 1'b0, "midrst_data",
        $sformatf("sum=%h cout=%b ovf=%b", o_sum[0], o_cout[0], o_ovf[0]), "all zero");
    exp_q[0].delete();
    presented[0] = 1'b0;
    @(posedge clk);
    #3;
    rst_arr[0] = 1'b1;
    mode[0] = 0;
    repeat (6) @(negedge clk);
    send(0, 256'd3, 256'd4, 1'b0, 1'b0, 256'd7, 1'b0, 1'b0);
    idle(0);
    wait_drain(0);

    // Random sweep on every configuration in parallel
    go = 1'b1;
    wait (done_cnt == N);
    for (int i = 0; i < N; i++) begin
      mode[i] = 0;
      wait_drain(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_pipelined.md
# adder_pipelined

Parametrised, carry-segmented pipelined adder/subtractor. It is the next generation of the registered benchmark adder: width and carry-chain pipeline depth are parameters, it adds a subtract mode and carry/borrow in, reports carry-out and signed overflow, and uses a valid/ready handshake with backpressure. It sits in the arithmetic benchmark circuits as a sweepable datapath for timing/area studies.

## Interface
- `WIDTH`, default 17: operand and sum width; legal range 1..256.
- `STAGES`, default 2: number of carry-chain segments, which is also the number of compute pipeline registers; legal range 1..WIDTH.
- `clk`, in, 1: sole clock; all flops are rising-edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: an operand set is offered.
- `in_ready`, out, 1: the block accepts the offered set this cycle.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B.
- `sub`, in, 1: 0 selects a+b+cin; 1 selects a−b−cin.
- `cin`, in, 1: carry-in for add; borrow-in for subtract.
- `out_valid`, out, 1: a result is presented.
- `out_ready`, in, 1: the consumer takes the result.
- `sum`, out, WIDTH: result modulo 2^WIDTH.
- `cout`, out, 1: carry-out for add; for subtract, 1 means no borrow.
- `ovf`, out, 1: signed (two's-complement) overflow.

## Operation
- Segmentation:
  - Segment width SW = ceil(WIDTH/STAGES).
  - Segment k covers bits [k·SW, min((k+1)·SW, WIDTH)−1].
  - Trailing segments may be narrower. Empty segments are not allowed, so STAGES must satisfy ceil(WIDTH/SW)=STAGES; elaboration errors otherwise.
- Operand preparation at stage 0 (input register):
  - Captures a, b' = sub ? ~b : b, and c0 = sub ? ~cin : cin.
  - Also captures the sign bits needed for ovf.
- Stage s (1..STAGES):
  - Adds segment s−1 of a and b' plus the carry from stage s−1, in a single (SW+1)-bit add.
  - Registers the segment sum and its carry-out.
  - Upper unprocessed operand segments travel in skew registers.
  - Completed lower sum segments travel in deskew registers.
- Output register is stage STAGES:
  - sum = concatenated segments.
  - cout = carry out of the top segment.
  - ovf = (a[W−1] == b'[W−1]) && (sum[W−1] != a[W−1]).
- Handshake:
  - Each stage has a valid bit.
  - The whole pipe advances on `adv` = !out_valid || out_ready (global stall, no bubble collapsing).
  - in_ready = adv.
  - A transfer occurs on a rising edge with in_valid && in_ready.
  - When adv=1 and in_valid=0, a bubble enters stage 0.
  - When adv=0, every stage register, including data, holds.
- Output hold: while out_valid && !out_ready, sum, cout and ovf are stable.
- Data registers have no reset requirement. Valid bits must reset.

## Timing
- Reset (rst_n=0, asynchronous):
  - All stage valid bits clear immediately.
  - out_valid=0, in_ready=1, sum=0, cout=0, ovf=0.
  - Output data registers are reset to zero.
- Reset mid-operation:
  - All in-flight operations are discarded.
  - No result emerges after deassertion.
  - The first post-reset edge with in_valid accepts normally.
- Latency:
  - A set accepted at edge T drives out_valid=1 after edge T+STAGES when no stall occurs.
  - Example: STAGES=2, accepted at edge 0, result visible after edge 2.
- Throughput: one result per cycle while out_ready=1.
- Stall: each cycle with out_valid=1 and out_ready=0 delays every in-flight operation by exactly one cycle.
- Simultaneous events:
  - With out_valid=1 and out_ready=1 in the same cycle as in_valid=1, both the output transfer and the input acceptance occur.
  - No data is lost or duplicated.
- Ordering: strictly FIFO; results emerge in acceptance order.

## Test plan
- Carry across segments (WIDTH=17, STAGES=2, SW=9):
  - Stimulus: a=0x1FFFF, b=0x00001, sub=0, cin=0.
  - Required: sum=0x00000, cout=1, ovf=0, out_valid two edges after accept.
- Subtract with borrow:
  - Stimulus: a=5, b=7, sub=1, cin=0.
  - Required: sum=0x1FFFE, cout=0, ovf=0.
  - Stimulus: a=7, b=5, sub=1, cin=1.
  - Required: sum=1, cout=1.
- Signed overflow:
  - Stimulus: a=0x0FFFF, b=1, add.
  - Required: sum=0x10000, ovf=1.
  - Stimulus: a=0x10000, b=1, sub.
  - Required: sum=0x0FFFF, ovf=1.
- Backpressure: stream 8 back-to-back random sets, holding out_ready=0 for 3 cycles mid-stream.
  - Required: in_ready=0 during the stall.
  - Required: outputs stable during the stall.
  - Required: all 8 results correct and in order.
  - Required: no duplicates.
- Reset mid-operation: accept 2 sets, then pulse rst_n low between clock edges.
  - Required: out_valid=0 immediately.
  - Required: no stale results afterwards.
  - Required: a new set a=3, b=4 yields 7.
- Parameter sweep: run random reference-model comparison (≥1000 vectors, both modes, random out_ready) for these (WIDTH, STAGES) pairs:
  - (1,1), (8,1), (17,2), (17,17), (64,4), (32,3) (SW=11; segments 11/11/10).
  - Required: latency equals STAGES in every configuration.
